// File: rtl/router_pkg.sv
// Shared router definitions: flit control-bit positions, the header parser FSM state,
// and the destination-to-one-hot decode used by the header parsing units.
// Control bits sit directly above the payload: in_data[DATA_W +: 3] = {vld, sop, eop}.
package router_pkg;

  // Bit positions inside the 3-bit control field that sits above the payload.
  localparam int VLD_BIT = 2;
  localparam int SOP_BIT = 1;
  localparam int EOP_BIT = 0;

  // Widest select onehot_dec can produce.
  localparam int MAX_PORTS = 32;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } hpu_state_t;

  // One-hot select for destination d; all-zero when d is not a legal port.
  function automatic logic [MAX_PORTS-1:0] onehot_dec(input logic [31:0] d,
                                                      input int unsigned num_ports);
    onehot_dec = (d < num_ports) ? (32'd1 << d) : 32'd0;
  endfunction

endpackage

// File: rtl/hpu_route_rot.sv
// Source-route rotate: drops the low HOP_W route bits (this hop's destination) and
// zero-fills the top of the route field so the next hop finds its dest in the low bits.
// Ports: payload_i (DATA_W) in, payload_o (DATA_W) out; purely combinational.
module hpu_route_rot #(
  parameter int HOP_W   = 3,
  parameter int ROUTE_W = 15,
  parameter int DATA_W  = 32
) (
  input  logic [DATA_W-1:0] payload_i,
  output logic [DATA_W-1:0] payload_o
);

  logic [ROUTE_W-1:0] route_rot;

  assign route_rot = {{HOP_W{1'b0}}, payload_i[ROUTE_W-1:HOP_W]};

  // Bits above the route field are user payload and pass through untouched.
  generate
    if (ROUTE_W < DATA_W) begin : g_upper
      assign payload_o = {payload_i[DATA_W-1:ROUTE_W], route_rot};
    end else begin : g_full
      assign payload_o = route_rot;
    end
  endgenerate

endmodule

// File: rtl/hpu_param.sv
// Header parsing unit: decodes the per-hop destination of a header flit into a one-hot
// crossbar select, rotates the route field, holds the select for the packet, and
// registers the flit with 1-cycle latency. Misrouted packets are discarded whole.
// Ports: clk/reset (async, active-high); in_req/in_data flit in; out_req/out_data/sel
// registered flit and select; err_dest/err_seq one-cycle error pulses in the emit cycle.
module hpu_param
  import router_pkg::*;
#(
  parameter  int NUM_PORTS = 5,
  parameter  int HOP_W     = 3,
  parameter  int ROUTE_W   = 15,
  parameter  int DATA_W    = 32,
  localparam int LINK_W    = DATA_W + 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_req,
  input  logic [LINK_W-1:0]    in_data,
  output logic                 out_req,
  output logic [LINK_W-1:0]    out_data,
  output logic [NUM_PORTS-1:0] sel,
  output logic                 err_dest,
  output logic                 err_seq
);

  logic [2:0]        ctrl;
  logic              f_vld, f_sop, f_eop, accept;
  logic [HOP_W-1:0]  dest;
  logic [NUM_PORTS-1:0] dec_sel;
  logic              dest_ok;
  logic [DATA_W-1:0] rot_payload;

  hpu_state_t           state_q, state_d;
  logic [NUM_PORTS-1:0] held_q, held_d;
  // Set while the rest of a bad-dest packet is being discarded.
  logic                 drop_q, drop_d;
  logic                 out_req_q, out_req_d;
  logic [LINK_W-1:0]    out_data_q, out_data_d;
  logic [NUM_PORTS-1:0] sel_q, sel_d;
  logic                 err_dest_q, err_dest_d;
  logic                 err_seq_q, err_seq_d;

  assign ctrl    = in_data[LINK_W-1:DATA_W];
  assign f_vld   = ctrl[VLD_BIT];
  assign f_sop   = ctrl[SOP_BIT];
  assign f_eop   = ctrl[EOP_BIT];
  assign accept  = in_req && (f_vld || f_sop || f_eop);
  assign dest    = in_data[HOP_W-1:0];
  assign dec_sel = NUM_PORTS'(onehot_dec(32'(dest), NUM_PORTS));
  assign dest_ok = |dec_sel;

  hpu_route_rot #(
    .HOP_W  (HOP_W),
    .ROUTE_W(ROUTE_W),
    .DATA_W (DATA_W)
  ) u_rot (
    .payload_i(in_data[DATA_W-1:0]),
    .payload_o(rot_payload)
  );

  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    drop_d     = drop_q;
    out_req_d  = 1'b0;
    out_data_d = '0;
    sel_d      = '0;
    err_dest_d = 1'b0;
    err_seq_d  = 1'b0;

    if (accept) begin
      if (f_sop) begin
        // A header always starts a fresh packet; one arriving mid-packet truncates it.
        err_seq_d = (state_q == PKT);
        state_d   = f_eop ? IDLE : PKT;
        if (dest_ok) begin
          out_req_d  = 1'b1;
          out_data_d = {ctrl, rot_payload};
          sel_d      = dec_sel;
          held_d     = f_eop ? '0 : dec_sel;
          drop_d     = 1'b0;
        end else begin
          err_dest_d = 1'b1;
          held_d     = '0;
          drop_d     = !f_eop;
        end
      end else if (state_q == PKT) begin
        if (!drop_q) begin
          out_req_d  = 1'b1;
          out_data_d = in_data;
          sel_d      = held_q;
        end
        if (f_eop) begin
          state_d = IDLE;
          held_d  = '0;
          drop_d  = 1'b0;
        end
      end else begin
        // Body/eop with no open packet: drop it and flag the framing error.
        err_seq_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      held_q     <= '0;
      drop_q     <= 1'b0;
      out_req_q  <= 1'b0;
      out_data_q <= '0;
      sel_q      <= '0;
      err_dest_q <= 1'b0;
      err_seq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      drop_q     <= drop_d;
      out_req_q  <= out_req_d;
      out_data_q <= out_data_d;
      sel_q      <= sel_d;
      err_dest_q <= err_dest_d;
      err_seq_q  <= err_seq_d;
    end
  end

  assign out_req  = out_req_q;
  assign out_data = out_data_q;
  assign sel      = sel_q;
  assign err_dest = err_dest_q;
  assign err_seq  = err_seq_q;

endmodule

// File: tb/tb_hpu_param.sv
// Directed bench for hpu_param with default parameters: each step drives one cycle of
// input just after a rising edge and checks the registered outputs 1 time unit after
// the following rising edge.
module tb_hpu_param;

  localparam int NUM_PORTS = 5;
  localparam int DATA_W    = 32;
  localparam int LINK_W    = DATA_W + 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_req = 1'b0;
  logic [LINK_W-1:0]    in_data = '0;
  logic                 out_req;
  logic [LINK_W-1:0]    out_data;
  logic [NUM_PORTS-1:0] sel;
  logic                 err_dest;
  logic                 err_seq;

  int cmp_cnt = 0;
  int err_cnt = 0;

  hpu_param dut (
    .clk     (clk),
    .reset   (reset),
    .in_req  (in_req),
    .in_data (in_data),
    .out_req (out_req),
    .out_data(out_data),
    .sel     (sel),
    .err_dest(err_dest),
    .err_seq (err_seq)
  );

  always #5 clk = ~clk;

  function automatic logic [LINK_W-1:0] mk(input logic v, input logic s, input logic e,
                                           input logic [DATA_W-1:0] p);
    mk = {v, s, e, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the control outputs as one packed vector {out_req, sel, err_dest, err_seq}.
  task automatic chk_ctl(input string tag, input logic r, input logic [NUM_PORTS-1:0] s,
                         input logic ed, input logic es);
    chk(tag, {56'd0, out_req, sel, err_dest, err_seq}, {56'd0, r, s, ed, es});
  endtask

  // Present one cycle of input, then wait for the edge that registers it.
  task automatic step(input logic r, input logic [LINK_W-1:0] d);
    in_req  = r;
    in_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    @(posedge clk);
    #1;
    chk_ctl("reset_ctl", 1'b0, 5'b00000, 1'b0, 1'b0);
    chk("reset_data", 64'(out_data), 64'd0);
    reset = 1'b0;

    // 1: 3-flit packet to port 2, route 15'h1A32 rotates to 15'h0346
    step(1'b1, mk(1'b1, 1'b1, 1'b0, {17'h12345, 15'h1A32}));
    chk_ctl("t1_hdr_ctl", 1'b1, 5'b00100, 1'b0, 1'b0);
    chk("t1_hdr_data", 64'(out_data), 64'(mk(1'b1, 1'b1, 1'b0, {17'h12345, 15'h0346})));
    step(1'b1, mk(1'b1, 1'b0, 1'b0, 32'hDEADBEEF));
    chk_ctl("t1_body_ctl", 1'b1, 5'b00100, 1'b0, 1'b0);
    chk("t1_body_data", 64'(out_data), 64'(mk(1'b1, 1'b0, 1'b0, 32'hDEADBEEF)));
    step(1'b1, mk(1'b1, 1'b0, 1'b1, 32'h0BADF00D));
    chk_ctl("t1_eop_ctl", 1'b1, 5'b00100, 1'b0, 1'b0);
    chk("t1_eop_data", 64'(out_data), 64'(mk(1'b1, 1'b0, 1'b1, 32'h0BADF00D)));
    step(1'b0, '0);
    chk_ctl("t1_after", 1'b0, 5'b00000, 1'b0, 1'b0);
    // in_req=1 with no control bit set is not a flit
    step(1'b1, mk(1'b0, 1'b0, 1'b0, 32'h00000002));
    chk_ctl("t1_nobits", 1'b0, 5'b00000, 1'b0, 1'b0);

    // 2: bad dest 6 discards the whole packet
    step(1'b1, mk(1'b1, 1'b1, 1'b0, 32'h00000006));
    chk_ctl("t2_bad_hdr", 1'b0, 5'b00000, 1'b1, 1'b0);
    step(1'b1, mk(1'b1, 1'b0, 1'b0, 32'h11111111));
    chk_ctl("t2_bad_body", 1'b0, 5'b00000, 1'b0, 1'b0);
    step(1'b1, mk(1'b1, 1'b0, 1'b1, 32'h22222222));
    chk_ctl("t2_bad_eop", 1'b0, 5'b00000, 1'b0, 1'b0);
    step(1'b1, mk(1'b1, 1'b1, 1'b0, 32'h00000000));
    chk_ctl("t2_good_hdr", 1'b1, 5'b00001, 1'b0, 1'b0);
    step(1'b1, mk(1'b1, 1'b0, 1'b1, 32'h33333333));
    chk_ctl("t2_good_eop", 1'b1, 5'b00001, 1'b0, 1'b0);

    // 3: in_req gaps keep the held select; flit bits on the bus are ignored
    step(1'b1, mk(1'b1, 1'b1, 1'b0, 32'h00000001));
    chk_ctl("t3_hdr", 1'b1, 5'b00010, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, mk(1'b1, 1'b1, 1'b1, 32'h00000004));
      chk_ctl("t3_gap1", 1'b0, 5'b00000, 1'b0, 1'b0);
    end
    step(1'b1, mk(1'b1, 1'b0, 1'b0, 32'h44444444));
    chk_ctl("t3_body", 1'b1, 5'b00010, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0);
      chk_ctl("t3_gap2", 1'b0, 5'b00000, 1'b0, 1'b0);
    end
    step(1'b1, mk(1'b1, 1'b0, 1'b1, 32'h55555555));
    chk_ctl("t3_eop", 1'b1, 5'b00010, 1'b0, 1'b0);

    // 4: new sop (dest 1) mid-packet (dest 4) resyncs
    step(1'b1, mk(1'b1, 1'b1, 1'b0, 32'h00000004));
    chk_ctl("t4_hdr4", 1'b1, 5'b10000, 1'b0, 1'b0);
    step(1'b1, mk(1'b1, 1'b0, 1'b0, 32'h66666666));
    chk_ctl("t4_body4", 1'b1, 5'b10000, 1'b0, 1'b0);
    step(1'b1, mk(1'b1, 1'b1, 1'b0, 32'h00000001));
    chk_ctl("t4_resync", 1'b1, 5'b00010, 1'b0, 1'b1);
    step(1'b1, mk(1'b1, 1'b0, 1'b1, 32'h77777777));
    chk_ctl("t4_eop1", 1'b1, 5'b00010, 1'b0, 1'b0);

    // 5: single-flit packet to port 3, then an orphan body flit
    step(1'b1, mk(1'b1, 1'b1, 1'b1, {17'h00000, 15'h7FFB}));
    chk_ctl("t5_single", 1'b1, 5'b01000, 1'b0, 1'b0);
    chk("t5_single_data", 64'(out_data), 64'(mk(1'b1, 1'b1, 1'b1, {17'h00000, 15'h0FFF})));
    step(1'b1, mk(1'b1, 1'b0, 1'b0, 32'h88888888));
    chk_ctl("t5_orphan", 1'b0, 5'b00000, 1'b0, 1'b1);
    chk("t5_orphan_data", 64'(out_data), 64'd0);

    // Out-of-sequence sop with bad dest flags both errors; its eop is silently dropped
    step(1'b1, mk(1'b1, 1'b1, 1'b0, 32'h00000002));
    chk_ctl("t7_hdr", 1'b1, 5'b00100, 1'b0, 1'b0);
    step(1'b1, mk(1'b1, 1'b1, 1'b0, 32'h00000007));
    chk_ctl("t7_both", 1'b0, 5'b00000, 1'b1, 1'b1);
    step(1'b1, mk(1'b1, 1'b0, 1'b1, 32'h99999999));
    chk_ctl("t7_eop", 1'b0, 5'b00000, 1'b0, 1'b0);

    // 6: reset mid-packet clears outputs asynchronously
    step(1'b1, mk(1'b1, 1'b1, 1'b0, 32'h00000002));
    chk_ctl("t6_hdr", 1'b1, 5'b00100, 1'b0, 1'b0);
    in_req = 1'b0;
    reset  = 1'b1;
    #1;
    chk_ctl("t6_async", 1'b0, 5'b00000, 1'b0, 1'b0);
    chk("t6_async_data", 64'(out_data), 64'd0);
    #1;
    reset = 1'b0;
    step(1'b1, mk(1'b1, 1'b0, 1'b0, 32'hAAAAAAAA));
    chk_ctl("t6_body", 1'b0, 5'b00000, 1'b0, 1'b1);
    step(1'b0, '0);
    chk_ctl("t6_idle", 1'b0, 5'b00000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
